// File: rtl/ifetch_pkg.sv
// Shared types and constants for the queued instruction fetch stage.
// Fetch entries, PC select encodings and instruction size.
package ifetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 32;

  localparam logic [1:0] PC_SEL_HOLD  = 2'd0;
  localparam logic [1:0] PC_SEL_SEQ   = 2'd1;
  localparam logic [1:0] PC_SEL_REDIR = 2'd2;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory and decode handshake bundle for ifetch_queue.
// master = fetch stage, slave = memory/decode side.
interface ifetch_queue_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc4
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc4
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Circular fetch queue with synchronous flush.
// Flush clears pointers and count; storage is left as-is.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  assign dout  = mem[head];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Queued instruction fetch: PC, 1-cycle imem issue, kill, misalign halt.
// Responses land in fetch_fifo and drain to decode via valid/ready.
import ifetch_pkg::*;

module ifetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            halt_out,
  ifetch_queue_if.master  bus
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_nxt;
  logic [XLEN-1:0]   req_pc;
  logic [1:0]        pc_sel;
  logic              inflight;
  logic              misalign;
  logic              kill;
  logic              fetch_ok;
  logic              pc_bad;
  logic              credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;

  assign halt_out = halt_in | misalign;
  assign kill     = rst | redirect_valid;
  assign pc_bad   = |pc[ALIGN_BITS-1:0];
  assign fetch_ok = !rst && !halt_out && !redirect_valid;
  // A pop this cycle earns no credit; keeps issue off the decode path.
  assign credit   = (count + CW'(inflight)) < CW'(DEPTH);
  assign issue    = fetch_ok && credit && !pc_bad;

  assign push = inflight && !kill;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.out_valid = !fifo_empty && !redirect_valid;
  assign bus.out_pc    = head[2*XLEN-1:XLEN];
  assign bus.out_instr = head[XLEN-1:0];
  assign bus.out_pc4   = bus.out_pc + STEP;

  always_comb begin
    pc_sel = PC_SEL_HOLD;
    unique case (1'b1)
      redirect_valid: pc_sel = PC_SEL_REDIR;
      issue:          pc_sel = PC_SEL_SEQ;
      default:        ;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    case (pc_sel)
      PC_SEL_REDIR: pc_nxt = redirect_target;
      PC_SEL_SEQ:   pc_nxt = pc + STEP;
      default:      pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      inflight <= issue;
      if (issue) req_pc <= pc;
      if (fetch_ok && pc_bad) misalign <= 1'b1;
    end
  end

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .flush (kill),
    .push  (push),
    .pop   (pop),
    .din   ({req_pc, bus.imem_rdata}),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!kill && push && !pop) assert (!fifo_full);
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, back-pressure, redirect,
// misalign, halt drain, PC wrap and mid-stream reset.
import ifetch_pkg::*;

module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        halt_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_out;
  logic        rst_w;
  logic        halt_w;

  int n_checks;
  int n_fail;

  ifetch_queue_if #(.XLEN(32)) ifc0 ();
  ifetch_queue_if #(.XLEN(32)) ifc1 ();

  ifetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .ALIGN_BITS(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .halt_in         (halt_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_out        (halt_out),
    .bus             (ifc0)
  );

  ifetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .ALIGN_BITS(2)
  ) dut_w (
    .clk             (clk),
    .rst             (rst_w),
    .halt_in         (1'b0),
    .redirect_valid  (1'b0),
    .redirect_target (32'h0),
    .halt_out        (halt_w),
    .bus             (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: mem[a] = a | 0x13, one-cycle latency.
  always @(posedge clk) ifc0.imem_rdata <= ifc0.imem_addr | 32'h13;
  always @(posedge clk) ifc1.imem_rdata <= ifc1.imem_addr | 32'h13;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    next();
    rst = 1'b1;
    halt_in = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    ifc0.out_ready = rdy;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next();
    rst = 1'b1;
    ifc0.out_ready = 1'b0;
    next();
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req got %b want 0", ifc0.imem_req);
    end
    n_checks++;
    if (ifc0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", ifc0.out_valid);
    end
    n_checks++;
    if (halt_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_halt0 got %b want 0", halt_out);
    end
    halt_in = 1'b1;
    #1;
    n_checks++;
    if (halt_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_halt1 got %b want 1", halt_out);
    end
    halt_in = 1'b0;
  endtask

  task automatic test_streaming();
    fetch_entry_t got;
    fetch_entry_t exp;
    do_reset(1'b1);
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b1 || ifc0.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL stream_c0_req got %b/%h want 1/0", ifc0.imem_req, ifc0.imem_addr);
    end
    n_checks++;
    if (ifc0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_c0_valid got %b want 0", ifc0.out_valid);
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b0 || ifc0.imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL stream_c1 got %b/%h want 0/4", ifc0.out_valid, ifc0.imem_addr);
    end
    for (int k = 0; k < 8; k++) begin
      next();
      #2;
      got = '{pc: ifc0.out_pc, instr: ifc0.out_instr};
      exp = '{pc: 32'(k * 4), instr: 32'(k * 4) | 32'h13};
      n_checks++;
      if (ifc0.out_valid !== 1'b1 || got !== exp) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%b %h want v=1 %h", k, ifc0.out_valid, got, exp);
      end
      n_checks++;
      if (ifc0.out_pc4 !== 32'(k * 4 + 4)) begin
        n_fail++;
        $display("FAIL stream_pc4_%0d got %h want %h", k, ifc0.out_pc4, 32'(k * 4 + 4));
      end
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    reqs = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next();
      #2;
      if (ifc0.imem_req === 1'b1) reqs++;
      if (c == 4) begin
        n_checks++;
        if (ifc0.imem_req !== 1'b0) begin
          n_fail++; $display("FAIL bp_req_c4 got %b want 0", ifc0.imem_req);
        end
      end
    end
    n_checks++;
    if (reqs != 4) begin
      n_fail++; $display("FAIL bp_reqs got %0d want 4", reqs);
    end
    next();
    ifc0.out_ready = 1'b1;
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_nocredit got %b want 0", ifc0.imem_req);
    end
    n_checks++;
    if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_pop0 got %b/%h want 1/0", ifc0.out_valid, ifc0.out_pc);
    end
    for (int i = 1; i < 5; i++) begin
      next();
      #2;
      n_checks++;
      if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL bp_pop%0d got %b/%h want 1/%h", i, ifc0.out_valid, ifc0.out_pc, 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    #2;
    repeat (4) next();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b0 || ifc0.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_cycle got v=%b r=%b want 0/0", ifc0.out_valid, ifc0.imem_req);
    end
    next();
    redirect_valid = 1'b0;
    ifc0.out_ready = 1'b1;
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b1 || ifc0.imem_addr !== 32'h100 || ifc0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_c5 got r=%b a=%h v=%b want 1/100/0",
               ifc0.imem_req, ifc0.imem_addr, ifc0.out_valid);
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_c6 got v=%b pc=%h want 0", ifc0.out_valid, ifc0.out_pc);
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'h100 || ifc0.out_instr !== 32'h113) begin
      n_fail++;
      $display("FAIL redir_first got %b/%h/%h want 1/100/113",
               ifc0.out_valid, ifc0.out_pc, ifc0.out_instr);
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_second got %b/%h want 1/104", ifc0.out_valid, ifc0.out_pc);
    end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mis_c0_req got %b want 0", ifc0.imem_req);
    end
    next();
    redirect_valid = 1'b0;
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b0 || ifc0.imem_addr !== 32'h102) begin
      n_fail++;
      $display("FAIL mis_c1 got r=%b a=%h want 0/102", ifc0.imem_req, ifc0.imem_addr);
    end
    for (int c = 2; c < 7; c++) begin
      next();
      #2;
      n_checks++;
      if (halt_out !== 1'b1 || ifc0.imem_req !== 1'b0 || ifc0.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mis_c%0d got h=%b r=%b v=%b want 1/0/0",
                 c, halt_out, ifc0.imem_req, ifc0.out_valid);
      end
    end
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    #2;
    n_checks++;
    if (halt_out !== 1'b0 || ifc0.imem_req !== 1'b1 || ifc0.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_clear got h=%b r=%b a=%h want 0/1/0",
               halt_out, ifc0.imem_req, ifc0.imem_addr);
    end
  endtask

  task automatic test_halt_drain();
    do_reset(1'b0);
    #2;
    repeat (3) next();
    halt_in = 1'b1;
    ifc0.out_ready = 1'b1;
    #2;
    n_checks++;
    if (halt_out !== 1'b1 || ifc0.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_c3 got h=%b r=%b want 1/0", halt_out, ifc0.imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next();
      #2;
      n_checks++;
      if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL halt_drain%0d got %b/%h want 1/%h", i, ifc0.out_valid, ifc0.out_pc, 32'(i * 4));
      end
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b0 || ifc0.imem_req !== 1'b0 || ifc0.imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL halt_frozen got v=%b r=%b a=%h want 0/0/c",
               ifc0.out_valid, ifc0.imem_req, ifc0.imem_addr);
    end
    next();
    halt_in = 1'b0;
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b1 || ifc0.imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL halt_resume got r=%b a=%h want 1/c", ifc0.imem_req, ifc0.imem_addr);
    end
    next();
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'hC) begin
      n_fail++;
      $display("FAIL halt_next got %b/%h want 1/c", ifc0.out_valid, ifc0.out_pc);
    end
  endtask

  task automatic test_wrap();
    next();
    rst_w = 1'b1;
    ifc1.out_ready = 1'b1;
    next();
    next();
    rst_w = 1'b0;
    #2;
    n_checks++;
    if (ifc1.imem_req !== 1'b1 || ifc1.imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_c0 got r=%b a=%h want 1/fffffffc", ifc1.imem_req, ifc1.imem_addr);
    end
    next();
    #2;
    n_checks++;
    if (ifc1.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_c1 got a=%h want 0", ifc1.imem_addr);
    end
    next();
    #2;
    n_checks++;
    if (ifc1.out_valid !== 1'b1 || ifc1.out_pc !== 32'hFFFF_FFFC || ifc1.out_pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_top got %b/%h/%h want 1/fffffffc/0",
               ifc1.out_valid, ifc1.out_pc, ifc1.out_pc4);
    end
    next();
    #2;
    n_checks++;
    if (ifc1.out_valid !== 1'b1 || ifc1.out_pc !== 32'h0 || ifc1.out_pc4 !== 32'h4) begin
      n_fail++;
      $display("FAIL wrap_zero got %b/%h/%h want 1/0/4",
               ifc1.out_valid, ifc1.out_pc, ifc1.out_pc4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    #2;
    repeat (5) next();
    rst = 1'b1;
    #2;
    n_checks++;
    if (ifc0.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rmid_req got %b want 0", ifc0.imem_req);
    end
    next();
    rst = 1'b0;
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b0 || ifc0.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_c1 got v=%b a=%h want 0/0", ifc0.out_valid, ifc0.imem_addr);
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_c2 got v=%b pc=%h want 0", ifc0.out_valid, ifc0.out_pc);
    end
    next();
    #2;
    n_checks++;
    if (ifc0.out_valid !== 1'b1 || ifc0.out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_c3 got %b/%h want 1/0", ifc0.out_valid, ifc0.out_pc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    rst_w = 1'b1;
    halt_in = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    ifc0.out_ready = 1'b0;
    ifc1.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt_drain();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
